// File: rtl/rv_mdu_iter.sv
// rv_mdu_iter: iterative RV32M multiply/divide unit, one bit per cycle.
// Optional MDU_EARLY_OUT_EN: trivial ops (x/0, overflow, x*0) skip CALC.
module rv_mdu_iter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [TAG_W-1:0] rd_addr_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] rd_addr_o
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [2:0]         op_q;
  logic [TAG_W-1:0]   tag_q;
  logic               sa_q, sb_q;
  logic               dz_q, ovf_q;
  logic [XLEN-1:0]    opd_q;
  logic [2*XLEN-1:0]  prod_q;
  logic [CW-1:0]      cnt_q;
  logic               done_q;
  logic [XLEN-1:0]    res_q;
  logic [TAG_W-1:0]   rdo_q;

  logic               accept;
  logic               sa_op, sb_op;
  logic               sgn_a, sgn_b;
  logic [XLEN-1:0]    mag_a, mag_b;
  logic               dz_in, ovf_in;

  logic [XLEN:0]      msum;
  logic [2*XLEN-1:0]  mul_nx;
  logic [XLEN:0]      dshift, ddiff;
  logic [2*XLEN-1:0]  div_nx;
  logic [2*XLEN-1:0]  prod_d;
  logic [2*XLEN-1:0]  pfin;
  logic [XLEN-1:0]    qfin, rfin;
  logic [XLEN-1:0]    fin_d;

  assign ready_o   = (state_q != S_CALC);
  assign busy_o    = (state_q == S_CALC);
  assign done_o    = done_q;
  assign result_o  = res_q;
  assign rd_addr_o = rdo_q;

  assign accept = start_i & ready_o & ~flush_i;

  // MULH, MULHSU, DIV, REM treat A as signed; MULH, DIV, REM treat B as signed
  assign sa_op = op_i[2] ? ~op_i[0] : (op_i[1] ^ op_i[0]);
  assign sb_op = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01);
  assign sgn_a = sa_op & rs1_data_i[XLEN-1];
  assign sgn_b = sb_op & rs2_data_i[XLEN-1];
  assign mag_a = sgn_a ? -rs1_data_i : rs1_data_i;
  assign mag_b = sgn_b ? -rs2_data_i : rs2_data_i;
  assign dz_in = ~|rs2_data_i;
  assign ovf_in = op_i[2] & ~op_i[0]
                & (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                & (&rs2_data_i);

`ifdef MDU_EARLY_OUT_EN
  logic            eo_hit;
  logic [XLEN-1:0] eo_res;

  assign eo_hit = op_i[2] ? (dz_in | ovf_in)
                          : (~|rs1_data_i | ~|rs2_data_i);
  assign eo_res = ~op_i[2] ? '0 :
                  dz_in    ? (op_i[1] ? rs1_data_i : '1) :
                             (op_i[1] ? '0 : rs1_data_i);
`endif

  // One iteration step and the sign-corrected, corner-case-aware result
  always_comb begin
    msum   = {1'b0, prod_q[2*XLEN-1:XLEN]}
           + (prod_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});
    mul_nx = {msum, prod_q[XLEN-1:1]};
    dshift = prod_q[2*XLEN-1:XLEN-1];
    ddiff  = dshift - {1'b0, opd_q};
    div_nx = ddiff[XLEN]
           ? {dshift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
           : {ddiff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    prod_d = op_q[2] ? div_nx : mul_nx;
    pfin   = (sa_q ^ sb_q) ? -prod_d : prod_d;
    qfin   = (sa_q ^ sb_q) ? -prod_d[XLEN-1:0] : prod_d[XLEN-1:0];
    rfin   = sa_q ? -prod_d[2*XLEN-1:XLEN] : prod_d[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 fin_d = pfin[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_d = pfin[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_d = dz_q  ? '1 :
                                      ovf_q ? {1'b1, {(XLEN-1){1'b0}}} :
                                              qfin;
      default:                fin_d = ovf_q ? '0 : rfin;
    endcase
  end

  // Control FSM plus datapath registers and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      tag_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      opd_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      rdo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          if (accept) begin
            op_q    <= op_i;
            tag_q   <= rd_addr_i;
            sa_q    <= sgn_a;
            sb_q    <= sgn_b;
            dz_q    <= dz_in;
            ovf_q   <= ovf_in;
            opd_q   <= op_i[2] ? mag_b : mag_a;
            prod_q  <= {{XLEN{1'b0}}, op_i[2] ? mag_a : mag_b};
            cnt_q   <= CW'(XLEN);
            state_q <= S_CALC;
`ifdef MDU_EARLY_OUT_EN
            if (eo_hit) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              res_q   <= eo_res;
              rdo_q   <= rd_addr_i;
            end
`endif
          end
        end
        S_CALC: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              res_q   <= fin_d;
              rdo_q   <= tag_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mdu_iter.sv
// tb_rv_mdu_iter: directed vectors for rv_mdu_iter with XLEN=32.
// Corner-case latency follows MDU_EARLY_OUT_EN when defined.
module tb_rv_mdu_iter;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int LF    = XLEN + 1;
`ifdef MDU_EARLY_OUT_EN
  localparam int LC = 1;
`else
  localparam int LC = XLEN + 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [2:0]       op_i;
  logic [XLEN-1:0]  rs1_data_i;
  logic [XLEN-1:0]  rs2_data_i;
  logic [TAG_W-1:0] rd_addr_i;
  logic             flush_i;
  logic             ready_o;
  logic             busy_o;
  logic             done_o;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] rd_addr_o;

  int total = 0;
  int bad   = 0;

  rv_mdu_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    @(negedge clk);
    start_i    = 1'b1;
    op_i       = op;
    rs1_data_i = a;
    rs2_data_i = b;
    rd_addr_i  = tag;
    @(posedge clk);
    #1;
    start_i    = 1'b0;
    rs1_data_i = 32'hDEADBEEF;
    rs2_data_i = 32'h0BADF00D;
    rd_addr_i  = ~tag;
  endtask

  task automatic wait_done(output int n, output bit calc_ok);
    n = 1;
    calc_ok = 1'b1;
    while (!done_o && n < 100) begin
      if (!(busy_o === 1'b1 && ready_o === 1'b0)) calc_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic count_done(input int cyc, output int d);
    d = 0;
    repeat (cyc) begin
      @(posedge clk);
      #1;
      if (done_o) d++;
    end
  endtask

  task automatic run(input string nm, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] tag, input logic [31:0] exp,
                     input int lat);
    int n;
    bit ok;
    issue(op, a, b, tag);
    wait_done(n, ok);
    chk({nm, " lat"}, n, lat);
    chk({nm, " res"}, result_o, exp);
    chk({nm, " tag"}, rd_addr_o, tag);
    chk({nm, " calc"}, ok, 1);
    @(posedge clk);
    #1;
    chk({nm, " pulse"}, done_o, 0);
    chk({nm, " hold"}, result_o, exp);
  endtask

  initial begin
    int n;
    int d;
    bit ok;
    rst = 1'b1;
    start_i = 1'b0;
    op_i = '0;
    rs1_data_i = '0;
    rs2_data_i = '0;
    rd_addr_i = '0;
    flush_i = 1'b0;
    #22;
    chk("rst ready", ready_o, 1);
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst res", result_o, 0);
    chk("rst rd", rd_addr_o, 0);
    @(negedge clk);
    rst = 1'b0;

    run("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, LF);
    run("mulh", 3'b001, 32'h80000000, 32'h80000000, 5'd2,
        32'h40000000, LF);
    run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,
        32'hFFFFFFFF, LF);
    run("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,
        32'hFFFFFFFE, LF);
    run("mulh2", 3'b001, 32'hFFFFFFFF, 32'd5, 5'd5, 32'hFFFFFFFF, LF);
    run("div", 3'b100, 32'hFFFFFFF9, 32'd2, 5'd17, 32'hFFFFFFFD, LF);
    run("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 5'd17, 32'hFFFFFFFF, LF);
    run("divu", 3'b101, 32'd100, 32'd7, 5'd17, 32'd14, LF);
    run("remu", 3'b111, 32'd100, 32'd7, 5'd17, 32'd2, LF);
    run("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd6,
        32'h80000000, LC);
    run("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd7, 32'd0, LC);
    run("divu0", 3'b101, 32'd123, 32'd0, 5'd8, 32'hFFFFFFFF, LC);
    run("rem0", 3'b110, 32'hFFFFFFFB, 32'd0, 5'd9, 32'hFFFFFFFB, LC);
    run("div0", 3'b100, 32'hFFFFFFFB, 32'd0, 5'd10, 32'hFFFFFFFF, LC);

    // back-to-back: second request held high during DONE of the first
    issue(3'b101, 32'd100, 32'd7, 5'd3);
    wait_done(n, ok);
    chk("b2b lat1", n, LF);
    chk("b2b res1", result_o, 14);
    chk("b2b rdy", ready_o, 1);
    start_i    = 1'b1;
    op_i       = 3'b111;
    rs1_data_i = 32'd100;
    rs2_data_i = 32'd7;
    rd_addr_i  = 5'd17;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("b2b drop", done_o, 0);
    chk("b2b acc", busy_o, 1);
    wait_done(n, ok);
    chk("b2b lat2", n, LF);
    chk("b2b res2", result_o, 2);
    chk("b2b tag2", rd_addr_o, 17);
    count_done(40, d);
    chk("b2b extra", d, 0);

    // flush at CALC cycle 10
    issue(3'b000, 32'd3, 32'd5, 5'd11);
    repeat (9) @(posedge clk);
    #1;
    chk("fl busy10", busy_o, 1);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("fl busy", busy_o, 0);
    chk("fl ready", ready_o, 1);
    count_done(40, d);
    chk("fl nodone", d, 0);
    chk("fl keep", result_o, 2);

    // start and flush together
    @(negedge clk);
    start_i = 1'b1;
    flush_i = 1'b1;
    op_i = 3'b101;
    rs1_data_i = 32'd9;
    rs2_data_i = 32'd3;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    chk("sf busy", busy_o, 0);
    count_done(40, d);
    chk("sf nodone", d, 0);

    // flush during DONE keeps the pulse but blocks a new accept
    issue(3'b101, 32'd50, 32'd5, 5'd12);
    wait_done(n, ok);
    chk("fd lat", n, LF);
    chk("fd res", result_o, 10);
    start_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    chk("fd busy", busy_o, 0);
    count_done(40, d);
    chk("fd nodone", d, 0);

    // async reset mid-CALC
    issue(3'b101, 32'd100, 32'd7, 5'd9);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar ready", ready_o, 1);
    chk("ar busy", busy_o, 0);
    chk("ar res", result_o, 0);
    chk("ar rd", rd_addr_o, 0);
    @(negedge clk);
    rst = 1'b0;
    count_done(40, d);
    chk("ar nodone", d, 0);

    run("post", 3'b000, 32'd6, 32'd7, 5'd31, 32'd42, LF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
